audio_sample_bridge: RTL

Multi-channel sample buffer between the MCP3008 audio ADC front end and the PWM DAC(s). Captures ADC samples tagged by channel into per-channel FIFOs and releases one sample per channel on each PWM "ready for next duty" event, replacing the unbuffered direct capture on the PWM ready edge. Provides prefill, underrun hold, overrun drop, sticky status, and midscale output while idle. Everything runs in one clock domain; ADC and PWM strobes arrive already synchronous to `clk`.

---
 rtl/audio_sample_bridge.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_sample_bridge.sv
// audio_sample_bridge
//
// Purpose: buffers tagged ADC samples in one FIFO per channel. On each PWM
// "ready for next duty" rising edge, it releases one sample per channel to
// the PWM duty outputs. A prefill phase lets every FIFO reach half depth
// before samples are released. An underrun sends the bridge back to prefill.
// While idle, the outputs sit at midscale.
//
// Optional feature: define BRIDGE_STATS_EN to build the 16-bit saturating
// overrun/underrun event counters. Without it, both count outputs read 0.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   enable        bridge enable; low flushes all FIFOs and forces IDLE
//   in_valid      ADC sample strobe, one write per high cycle
//   in_ch         channel tag of in_data (tags >= CHANNELS are ignored)
//   in_data       ADC sample
//   pwm_ready     PWM ready level; its rising edge is a pop event
//   clear_flags   clears sticky flags and counters (a new event wins)
//   duty_val      per-channel duty, channel c at [c*N +: N]
//   duty_valid    one-cycle pulse when duty_val is refreshed
//   fifo_level    per-channel occupancy, channel c at [c*LW +: LW]
//   overrun       sticky per-channel "sample dropped on full"
//   underrun      sticky per-channel "pop while empty"
//   overrun_cnt   overrun event count
//   underrun_cnt  underrun event count
module audio_sample_bridge #(
    parameter int N        = 10,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic [CW-1:0]          in_ch,
    input  logic [N-1:0]           in_data,
    input  logic                   pwm_ready,
    input  logic                   clear_flags,
    output logic [CHANNELS*N-1:0]  duty_val,
    output logic                   duty_valid,
    output logic [CHANNELS*LW-1:0] fifo_level,
    output logic [CHANNELS-1:0]    overrun,
    output logic [CHANNELS-1:0]    underrun,
    output logic [15:0]            overrun_cnt,
    output logic [15:0]            underrun_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [N-1:0] MIDSCALE = {1'b1, {(N-1){1'b0}}};

    state_t              state, next_state;
    logic                pwm_prev;
    logic                pop_evt;
    logic                active;
    logic                running;
    logic                ch_ok;
    logic                all_half;

    logic [N-1:0]        mem    [CHANNELS][DEPTH];
    logic [AW-1:0]       rd_ptr [CHANNELS];
    logic [AW-1:0]       wr_ptr [CHANNELS];
    logic [LW-1:0]       level  [CHANNELS];
    logic [N-1:0]        duty_r [CHANNELS];

    logic [CHANNELS-1:0] wr_req, push, pop, under, drop;
    logic [CHANNELS-1:0] overrun_r, underrun_r;

    // A write to a full FIFO is accepted only if the same channel pops on the
    // same edge. Otherwise the sample is dropped. An empty FIFO that sees a pop
    // event counts as an underrun even when a write lands in the same cycle.
    always_comb begin
        pop_evt  = pwm_ready & ~pwm_prev;
        active   = enable && (state != IDLE);
        running  = enable && (state == RUN);
        ch_ok    = (int'(in_ch) < CHANNELS);
        all_half = 1'b1;
        wr_req   = '0;
        push     = '0;
        pop      = '0;
        under    = '0;
        drop     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_req[c] = active && in_valid && ch_ok && (in_ch == CW'(c));
            pop[c]    = running && pop_evt && (level[c] != '0);
            under[c]  = running && pop_evt && (level[c] == '0);
            drop[c]   = wr_req[c] && (level[c] == LW'(DEPTH)) && !pop[c];
            push[c]   = wr_req[c] && !drop[c];
            if (level[c] < LW'(DEPTH / 2)) begin
                all_half = 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = FILL;
            FILL:    if (all_half) next_state = RUN;
            RUN:     if (|under) next_state = FILL;
            default: next_state = IDLE;
        endcase
        if (!enable) begin
            next_state = IDLE;
        end
    end

    // Sample storage has no reset. Flushing only clears the pointers and levels.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pwm_prev   <= 1'b0;
            duty_valid <= 1'b0;
            overrun_r  <= '0;
            underrun_r <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                duty_r[c] <= MIDSCALE;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                level[c]  <= '0;
            end
        end else begin
            state      <= next_state;
            pwm_prev   <= pwm_ready;
            duty_valid <= running && pop_evt;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!enable || state == IDLE) begin
                    duty_r[c] <= MIDSCALE;
                end else if (pop[c]) begin
                    duty_r[c] <= mem[c][rd_ptr[c]];
                end

                if (!enable) begin
                    rd_ptr[c] <= '0;
                    wr_ptr[c] <= '0;
                    level[c]  <= '0;
                end else begin
                    if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
                    if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
                    case ({push[c], pop[c]})
                        2'b10:   level[c] <= level[c] + LW'(1);
                        2'b01:   level[c] <= level[c] - LW'(1);
                        default: level[c] <= level[c];
                    endcase
                end

                if (drop[c])         overrun_r[c] <= 1'b1;
                else if (clear_flags) overrun_r[c] <= 1'b0;
                if (under[c])        underrun_r[c] <= 1'b1;
                else if (clear_flags) underrun_r[c] <= 1'b0;
            end
        end
    end

`ifdef BRIDGE_STATS_EN
    logic [15:0] ov_q, un_q;

    // Each counter counts at most once per cycle and saturates at 0xFFFF.
    // A new event takes priority over clear_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ov_q <= '0;
            un_q <= '0;
        end else begin
            if (|drop) begin
                if (ov_q != 16'hFFFF) ov_q <= ov_q + 16'd1;
            end else if (clear_flags) begin
                ov_q <= '0;
            end
            if (|under) begin
                if (un_q != 16'hFFFF) un_q <= un_q + 16'd1;
            end else if (clear_flags) begin
                un_q <= '0;
            end
        end
    end

    assign overrun_cnt  = ov_q;
    assign underrun_cnt = un_q;
`else
    assign overrun_cnt  = '0;
    assign underrun_cnt = '0;
`endif

    assign overrun  = overrun_r;
    assign underrun = underrun_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign duty_val[g*N +: N]     = duty_r[g];
        assign fifo_level[g*LW +: LW] = level[g];
    end

endmodule
